// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg -- shared definitions for the five-stage pipeline controller.
//   REG_W          : GPR number width (32 registers)
//   STG_*          : stage indices into the controller's valid vector
//   MATCH_*        : bit positions of a hazard match vector (EX/MEM/WB)
//   FWD_*          : bypass select encodings driven on fwd_rj / fwd_rkd
//   stage_info_t   : per-stage writeback attributes carried down the pipe
//   fwd_select()   : youngest-wins encoder from a match vector to FWD_*
package pipe_ctrl_pkg;

  localparam int REG_W = 5;
  typedef logic [REG_W-1:0] reg_num_t;

  localparam int N_STG   = 5;
  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  localparam int MATCH_EX  = 0;
  localparam int MATCH_MEM = 1;
  localparam int MATCH_WB  = 2;

  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_RF  = 2'd0;
  localparam fwd_sel_t FWD_EX  = 2'd1;
  localparam fwd_sel_t FWD_MEM = 2'd2;
  localparam fwd_sel_t FWD_WB  = 2'd3;

  typedef struct packed {
    reg_num_t dest;
    logic     gr_we;
    logic     is_load;
  } stage_info_t;

  // The youngest producer holds the most recent value, so EX beats MEM beats WB.
  function automatic fwd_sel_t fwd_select(input logic [2:0] match);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (match[MATCH_EX])       sel = FWD_EX;
    else if (match[MATCH_MEM]) sel = FWD_MEM;
    else if (match[MATCH_WB])  sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/pipe_hazard_cmp.sv
// pipe_hazard_cmp -- compares one ID source register against the
// destinations held in EX, MEM and WB.
//   src, src_en                 : source register number and read enable
//   es_/ms_/ws_valid            : stage holds a live instruction
//   es_/ms_/ws_gr_we, *_dest    : stage writes a GPR, and which one
//   match[2:0]                  : per-stage hit, indexed by MATCH_EX/MEM/WB
// r0 is hard-wired to zero, so a write to it never creates a dependency.
module pipe_hazard_cmp
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             src_en,
  input  logic             es_valid,
  input  logic             es_gr_we,
  input  logic [REG_W-1:0] es_dest,
  input  logic             ms_valid,
  input  logic             ms_gr_we,
  input  logic [REG_W-1:0] ms_dest,
  input  logic             ws_valid,
  input  logic             ws_gr_we,
  input  logic [REG_W-1:0] ws_dest,
  output logic [2:0]       match
);

  assign match[MATCH_EX]  = src_en & es_valid & es_gr_we & (es_dest != '0) & (es_dest == src);
  assign match[MATCH_MEM] = src_en & ms_valid & ms_gr_we & (ms_dest != '0) & (ms_dest == src);
  assign match[MATCH_WB]  = src_en & ws_valid & ws_gr_we & (ws_dest != '0) & (ws_dest == src);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- valid/allowin handshake, branch squash and RAW hazard control
// for a five-stage IF/ID/EX/MEM/WB pipeline.
//   clk, reset               : rising-edge clock, async active-high reset
//   if_ready_go, mem_ready_go: SRAM response valid for IF / MEM
//   id_rj*, id_rkd*          : ID source registers and read enables
//   id_dest, id_gr_we, id_is_load, id_br_taken : ID instruction attributes
//   pc_we                    : PC load enable
//   fs/ds/es/ms/ws_valid     : stage occupancy
//   fs2ds/ds2es/es2ms/ms2ws_en : inter-stage register load enables
//   id_stall, fwd_rj, fwd_rkd: hazard stall and bypass selects
// Build option PIPE_CTRL_FORWARD_EN: full bypassing, stall only on load-use.
// Without it every RAW dependency stalls ID until the producer retires.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             if_ready_go,
  input  logic             mem_ready_go,
  input  logic [REG_W-1:0] id_rj,
  input  logic [REG_W-1:0] id_rkd,
  input  logic             id_rj_en,
  input  logic             id_rkd_en,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_gr_we,
  input  logic             id_is_load,
  input  logic             id_br_taken,
  output logic             pc_we,
  output logic             fs_valid,
  output logic             ds_valid,
  output logic             es_valid,
  output logic             ms_valid,
  output logic             ws_valid,
  output logic             fs2ds_en,
  output logic             ds2es_en,
  output logic             es2ms_en,
  output logic             ms2ws_en,
  output logic             id_stall,
  output logic [1:0]       fwd_rj,
  output logic [1:0]       fwd_rkd
);

  logic [N_STG-1:0] vld;
  stage_info_t      es_info, ms_info, ws_info;

  logic ws_allowin, ms_allowin, es_allowin, ds_allowin, fs_allowin;
  logic br_kill;
  logic [2:0] match_rj, match_rkd;
  logic unused_load_flags;

  assign fs_valid = vld[STG_IF];
  assign ds_valid = vld[STG_ID];
  assign es_valid = vld[STG_EX];
  assign ms_valid = vld[STG_MEM];
  assign ws_valid = vld[STG_WB];

  // EX always completes in one cycle; MEM waits on the data SRAM.
  assign ws_allowin = 1'b1;
  assign ms_allowin = !ms_valid | (mem_ready_go & ws_allowin);
  assign es_allowin = !es_valid | ms_allowin;
  assign ds_allowin = !ds_valid | (!id_stall & es_allowin);
  assign fs_allowin = !fs_valid | (if_ready_go & ds_allowin);

  assign fs2ds_en = fs_valid & if_ready_go & ds_allowin;
  assign ds2es_en = ds_valid & !id_stall & es_allowin;
  assign es2ms_en = es_valid & ms_allowin;
  assign ms2ws_en = ms_valid & mem_ready_go & ws_allowin;

  assign pc_we = fs_allowin & !reset;

  // Only a branch actually leaving ID squashes; a stalled branch waits.
  assign br_kill = ds_valid & id_br_taken & ds2es_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld     <= '0;
      es_info <= '0;
      ms_info <= '0;
      ws_info <= '0;
    end else begin
      if (fs_allowin) vld[STG_IF]  <= 1'b1;
      if (ds_allowin) vld[STG_ID]  <= fs_valid & if_ready_go & !br_kill;
      if (es_allowin) vld[STG_EX]  <= ds_valid & !id_stall;
      if (ms_allowin) vld[STG_MEM] <= es_valid;
      if (ws_allowin) vld[STG_WB]  <= ms_valid & mem_ready_go;

      if (ds2es_en) es_info <= '{dest: id_dest, gr_we: id_gr_we, is_load: id_is_load};
      if (es2ms_en) ms_info <= es_info;
      if (ms2ws_en) ws_info <= ms_info;
    end
  end

  pipe_hazard_cmp u_cmp_rj (
    .src      (id_rj),
    .src_en   (id_rj_en),
    .es_valid (es_valid),
    .es_gr_we (es_info.gr_we),
    .es_dest  (es_info.dest),
    .ms_valid (ms_valid),
    .ms_gr_we (ms_info.gr_we),
    .ms_dest  (ms_info.dest),
    .ws_valid (ws_valid),
    .ws_gr_we (ws_info.gr_we),
    .ws_dest  (ws_info.dest),
    .match    (match_rj)
  );

  pipe_hazard_cmp u_cmp_rkd (
    .src      (id_rkd),
    .src_en   (id_rkd_en),
    .es_valid (es_valid),
    .es_gr_we (es_info.gr_we),
    .es_dest  (es_info.dest),
    .ms_valid (ms_valid),
    .ms_gr_we (ms_info.gr_we),
    .ms_dest  (ms_info.dest),
    .ws_valid (ws_valid),
    .ws_gr_we (ws_info.gr_we),
    .ws_dest  (ws_info.dest),
    .match    (match_rkd)
  );

`ifdef PIPE_CTRL_FORWARD_EN
  // Load data only exists after MEM, so a load in EX costs one bubble.
  assign id_stall = ds_valid & es_info.is_load
                  & (match_rj[MATCH_EX] | match_rkd[MATCH_EX]);
  assign fwd_rj   = fwd_select(match_rj);
  assign fwd_rkd  = fwd_select(match_rkd);
  // MEM/WB load flags travel with the instruction for downstream writeback muxing.
  assign unused_load_flags = ms_info.is_load ^ ws_info.is_load;
`else
  assign id_stall = ds_valid & ((|match_rj) | (|match_rkd));
  assign fwd_rj   = FWD_RF;
  assign fwd_rkd  = FWD_RF;
  assign unused_load_flags = es_info.is_load ^ ms_info.is_load ^ ws_info.is_load;
`endif

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk and reset; no other clock or reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous active-high reset.
REQ-004 if_ready_go  in  1  inst SRAM data valid for the instruction in IF.
REQ-005 mem_ready_go  in  1  data SRAM access complete for the instruction in MEM.
REQ-006 id_rj, id_rkd  in  5 each  ID source register numbers; id_rj_en, id_rkd_en  in  1 each  source actually read.
REQ-007 id_dest  in  5  ID destination; id_gr_we  in  1  ID writes GPR; id_is_load  in  1  ID is ld.w.
REQ-008 id_br_taken  in  1  branch/jump resolved taken in ID.
REQ-009 pc_we  out  1  PC register load enable (nextpc accepted).
REQ-010 fs_valid, ds_valid, es_valid, ms_valid, ws_valid  out  1 each  stage holds a live instruction.
REQ-011 fs2ds_en, ds2es_en, es2ms_en, ms2ws_en  out  1 each  inter-stage register load enables.
REQ-012 id_stall  out  1  RAW hazard holds ID.
REQ-013 fwd_rj, fwd_rkd  out  2 each  bypass select: 0 regfile, 1 EX, 2 MEM, 3 WB (only with FORWARD_EN).

Function
REQ-014 ws_allowin SHALL be 1; ms_allowin = !ms_valid | (mem_ready_go & ws_allowin); es_allowin = !es_valid | ms_allowin (EX ready_go = 1); ds_allowin = !ds_valid | (!id_stall & es_allowin); fs_allowin = !fs_valid | (if_ready_go & ds_allowin).
REQ-015 Each Xs2Ys_en SHALL equal Xs_valid & X_ready_go & Ys_allowin; pc_we SHALL equal fs_allowin & !reset.
REQ-016 On a clock edge with Ys_allowin=1, Ys_valid SHALL load the upstream stage's valid&ready_go; fs_valid SHALL load 1 when fs_allowin.
REQ-017 A taken branch (ds_valid & id_br_taken & ds2es_en) SHALL force fs2ds to carry valid=0 that cycle, killing exactly one wrong-path instruction (the one in IF).
REQ-018 id_br_taken while id_stall=1 SHALL have no effect until the stall clears.
REQ-019 Per stage EX/MEM/WB the block SHALL register dest, gr_we, is_load alongside valid, loaded by the corresponding _en.
REQ-020 Hazard match SHALL require stage valid, stage gr_we, stage dest != 0, source enable, and equal register numbers; r0 never matches.
REQ-021 Stage priority for matches SHALL be EX > MEM > WB (youngest wins).
REQ-022 Stall, bypass and enable outputs SHALL be combinational from current state and inputs; zero-cycle latency.
REQ-023 mem_ready_go=0 SHALL freeze MEM, EX, ID, IF in place; WB drains (ws_valid goes 0 next cycle).

Reset
REQ-024 While reset=1: all *_valid=0, all stage dest/gr_we/is_load=0, pc_we=0, all _en=0, id_stall=0, fwd_*=0.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight instructions immediately; first fs_valid=1 occurs on the first edge after reset deasserts.

Configuration
REQ-026 Macro PIPE_CTRL_FORWARD_EN defined: id_stall only when EX holds a matching load (load-use, one bubble); other matches drive fwd_* to 1/2/3.
REQ-027 Macro undefined: id_stall on any match in EX, MEM or WB; fwd_rj=fwd_rkd=0 always.

Structure
REQ-028 Shared package SHALL hold stage indices, FWD_RF/FWD_EX/FWD_MEM/FWD_WB constants and the 5-bit register-number width.
REQ-029 One sub-module pipe_hazard_cmp (one source vs three stages -> match vector) SHALL be instantiated twice (rj, rkd).

Verification
REQ-030 Reset release, if_ready_go=mem_ready_go=1, no hazards -> fs_valid cycle 1, ws_valid cycle 5, pc_we=1 every cycle.
REQ-031 add.w r4 in EX, ID reads rj=4 -> FORWARD_EN: fwd_rj=1, id_stall=0; without: id_stall=1 for 3 cycles.
REQ-032 ld.w r5 in EX, ID reads rkd=5 -> id_stall=1 exactly 1 cycle (FORWARD_EN), then fwd_rkd=2.
REQ-033 ID writes/reads r0, EX dest=0 gr_we=1 -> no stall, fwd=0.
REQ-034 id_br_taken=1 with ds2es_en=1 -> next cycle ds_valid=0, PC-target instruction enters IF.
REQ-035 mem_ready_go=0 for 4 cycles then reset mid-stall -> stages frozen, then all valid=0 on reset assertion.
